// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage and IF/ID pipeline register.
// Owns the PC, runs the variable-latency instruction memory handshake,
// applies branch/jump redirects resolved in D and honours hazard stalls.
// Optional build macro: FETCH_PERF_CTR_EN adds saturating perf counters;
// without it both counter ports are tied to zero.
//
// state   | meaning
// RUN     | requesting pc_f; an ack is consumed normally
// DISCARD | redirect arrived while a request was outstanding; the
//         | response for the old address is dropped, then pend_pc is used
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_f_i,
  input  logic        stall_d_i,
  input  logic        pcsrc_d_i,
  input  logic        jump_d_i,
  input  logic [31:0] pcbranch_d_i,
  input  logic [31:0] pcjump_d_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_d_o,
  output logic [31:0] pcplus4_d_o,
  output logic        valid_d_o,
  output logic        fetch_busy_o,
  output logic [31:0] fetched_cnt_o,
  output logic [31:0] bubble_cnt_o
);

  typedef enum logic {RUN, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] pend_pc;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        bubble;
  logic        load;

  assign redirect = (pcsrc_d_i | jump_d_i) & ~stall_d_i;
  assign target   = jump_d_i ? pcjump_d_i : pcbranch_d_i;
  assign pc_plus4 = pc_f + 32'd4;

  // The address always tracks pc_f, so it cannot move while a request waits.
  assign imem_req_o   = ~reset_i;
  assign imem_addr_o  = pc_f;
  assign fetch_busy_o = ((state == RUN) & ~imem_ack_i) | (state == DISCARD);

  // A stalled IF/ID holds; otherwise anything but a clean RUN ack is a bubble.
  assign bubble = ~stall_d_i & (redirect | (state == DISCARD) | ~imem_ack_i | stall_f_i);
  assign load   = ~stall_d_i & ~bubble;

  // PC / fetch state machine.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= RUN;
      pc_f    <= RESET_PC;
      pend_pc <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (redirect && imem_ack_i) begin
            pc_f <= target;
          end else if (redirect) begin
            pend_pc <= target;
            state   <= DISCARD;
          end else if (imem_ack_i && !stall_f_i) begin
            pc_f <= pc_plus4;
          end
        end
        DISCARD: begin
          if (imem_ack_i) begin
            pc_f  <= redirect ? target : pend_pc;
            state <= RUN;
          end else if (redirect) begin
            pend_pc <= target;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // IF/ID pipeline register; pcplus4 keeps its last value across bubbles.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      instr_d_o   <= 32'h0;
      pcplus4_d_o <= 32'h0;
      valid_d_o   <= 1'b0;
    end else if (load) begin
      instr_d_o   <= imem_rdata_i;
      pcplus4_d_o <= pc_plus4;
      valid_d_o   <= 1'b1;
    end else if (bubble) begin
      instr_d_o <= 32'h0;
      valid_d_o <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CTR_EN
  logic [31:0] fetched_cnt;
  logic [31:0] bubble_cnt;

  // Saturating counts of real loads and bubble loads (holds are not counted).
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetched_cnt <= 32'h0;
      bubble_cnt  <= 32'h0;
    end else begin
      if (load && fetched_cnt != 32'hFFFF_FFFF) fetched_cnt <= fetched_cnt + 32'd1;
      if (bubble && bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign fetched_cnt_o = fetched_cnt;
  assign bubble_cnt_o  = bubble_cnt;
`else
  assign fetched_cnt_o = 32'h0;
  assign bubble_cnt_o  = 32'h0;
`endif

endmodule
